// File: rtl/alu_share_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | Module  : alu_pkg                                                    |
// | Brief   : Shared widths, opcodes and FSM states for the ALU arbiter. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package alu_pkg;
  localparam int OPW  = 4;
  localparam int RESW = 5;
  localparam int OPCW = 3;

  localparam logic [OPCW-1:0] OP_ADD  = 3'd0;
  localparam logic [OPCW-1:0] OP_SUB  = 3'd1;
  localparam logic [OPCW-1:0] OP_AND  = 3'd2;
  localparam logic [OPCW-1:0] OP_OR   = 3'd3;
  localparam logic [OPCW-1:0] OP_NOT  = 3'd4;
  localparam logic [OPCW-1:0] OP_MUL  = 3'd5;
  localparam logic [OPCW-1:0] OP_XOR  = 3'd6;
  localparam logic [OPCW-1:0] OP_XNOR = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

`default_nettype wire

// File: rtl/alu_share_arbiter_if.sv
// +----------------------------------------------------------------------+
// | Module  : alu_share_arbiter_if                                       |
// | Brief   : Request/response bus between ALU clients and the arbiter.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface alu_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  import alu_pkg::*;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [OPW*NREQ-1:0]  req_a;
  logic [OPW*NREQ-1:0]  req_b;
  logic [OPCW*NREQ-1:0] req_op;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [RESW-1:0]      rsp_result;
  logic [IDW-1:0]       rsp_id;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_id
  );
endinterface

`default_nettype wire

// File: rtl/alu_core.sv
// +----------------------------------------------------------------------+
// | Module  : alu_core                                                   |
// | Brief   : Shared combinational 4-bit, 8-opcode ALU leaf.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_core
  import alu_pkg::*;
(
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  input  logic [OPCW-1:0] op,
  output logic [RESW-1:0] y
);
  logic [RESW-1:0] w_a;
  logic [RESW-1:0] w_b;

  assign w_a = {1'b0, a};
  assign w_b = {1'b0, b};

  // Operands are zero-extended first, so NOT/XNOR always set bit 4.
  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = w_a + w_b;
      OP_SUB:  y = w_a - w_b;
      OP_AND:  y = w_a & w_b;
      OP_OR:   y = w_a | w_b;
      OP_NOT:  y = ~w_a;
      OP_MUL:  y = w_a * w_b;
      OP_XOR:  y = w_a ^ w_b;
      OP_XNOR: y = ~(w_a ^ w_b);
      default: y = '0;
    endcase
  end
endmodule

`default_nettype wire

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// +----------------------------------------------------------------------+
// | Module  : rr_arbiter                                                 |
// | Brief   : Combinational round-robin pick starting at ptr, with wrap. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // Scan farthest-first so the candidate closest to ptr is written last and wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[wrap_idx(ptr, k)]) begin
        gnt                  = '0;
        gnt[wrap_idx(ptr, k)] = 1'b1;
        idx                  = wrap_idx(ptr, k);
      end
    end
  end
endmodule

`default_nettype wire

// File: rtl/alu_share_arbiter.sv
// +----------------------------------------------------------------------+
// | Module  : alu_share_arbiter                                          |
// | Brief   : Round-robin sharing of one ALU among NREQ requesters.      |
// |           Optional perf counters when ALU_ARB_PERF_EN is defined.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_share_arbiter_if.slave  bus,
  output logic                busy
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [15:0]         perf_ops,
  output logic [15:0]         perf_stall
`endif
);
  state_t          r_state;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_gid;
  logic [OPW-1:0]  r_a;
  logic [OPW-1:0]  r_b;
  logic [OPCW-1:0] r_op;
  logic [RESW-1:0] r_result;
  logic [IDW-1:0]  r_rsp_id;
  logic            r_rsp_valid;

  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_idx;
  logic            w_any;
  logic [RESW-1:0] w_alu;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req (bus.req_valid),
    .ptr (r_ptr),
    .gnt (w_gnt),
    .idx (w_idx),
    .any (w_any)
  );

  alu_core u_alu (
    .a  (r_a),
    .b  (r_b),
    .op (r_op),
    .y  (w_alu)
  );

  // Grant is combinational in IDLE and held off while reset is asserted.
  assign bus.req_ready  = (r_state == IDLE && rst_n) ? w_gnt : '0;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_result = r_result;
  assign bus.rsp_id     = r_rsp_id;
  assign busy           = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gid       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_result    <= '0;
      r_rsp_id    <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_a     <= bus.req_a[w_idx*OPW +: OPW];
            r_b     <= bus.req_b[w_idx*OPW +: OPW];
            r_op    <= bus.req_op[w_idx*OPCW +: OPCW];
            r_gid   <= w_idx;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_result    <= w_alu;
          r_rsp_id    <= r_gid;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_ptr       <= (r_gid == IDW'(NREQ - 1)) ? '0 : r_gid + 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_PERF_EN
  logic [15:0] r_perf_ops;
  logic [15:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_ops   <= '0;
      r_perf_stall <= '0;
    end else begin
      if (r_state == RESP && bus.rsp_ready && r_perf_ops != 16'hFFFF)
        r_perf_ops <= r_perf_ops + 16'd1;
      if (r_rsp_valid && !bus.rsp_ready && r_perf_stall != 16'hFFFF)
        r_perf_stall <= r_perf_stall + 16'd1;
    end
  end

  assign perf_ops   = r_perf_ops;
  assign perf_stall = r_perf_stall;
`endif
endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// +----------------------------------------------------------------------+
// | Module  : tb_alu_share_arbiter                                       |
// | Brief   : Directed self-checking bench for alu_share_arbiter.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  alu_share_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus();

`ifdef ALU_ARB_PERF_EN
  logic [15:0] perf_ops;
  logic [15:0] perf_stall;
  logic [15:0] p_stall0;
  logic [15:0] p_ops0;
`endif

  alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_ops   (perf_ops),
    .perf_stall (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    bus.req_a[id*4 +: 4]  = a;
    bus.req_b[id*4 +: 4]  = b;
    bus.req_op[id*3 +: 3] = op;
  endtask

  // One full transaction from a lone requester with rsp_ready held high.
  task automatic run_op(input string tag, input int id, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] op, input logic [4:0] exp);
    set_req(id, a, b, op);
    bus.req_valid = NREQ'(1 << id);
    #1;
    check({tag, "_ready"}, 32'(bus.req_ready), 32'(1 << id));
    tick();
    bus.req_valid = '0;
    check({tag, "_exec_valid"}, 32'(bus.rsp_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_result"}, 32'(bus.rsp_result), 32'(exp));
    check({tag, "_id"}, 32'(bus.rsp_id), 32'(id));
    tick();
    check({tag, "_done"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b1;
    #2;
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_result", 32'(bus.rsp_result), 32'd0);
    check("rst_id", 32'(bus.rsp_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    run_op("add_r1", 1, 4'hF, 4'h1, OP_ADD, 5'h10);

    // Reset while a response is pending: output must drop without a clock.
    set_req(2, 4'h3, 4'h5, OP_SUB);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0100;
    #1;
    check("mid_ready", 32'(bus.req_ready), 32'b0100);
    tick();
    bus.req_valid = '0;
    tick();
    check("mid_valid", 32'(bus.rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    tick();

    // All requesters valid: rr_ptr restarted at 0 so order is 0,1,2,3,0,1.
    for (int i = 0; i < NREQ; i++) set_req(i, 4'(i), 4'h1, OP_ADD);
    bus.req_valid = '1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("rr_ready", 32'(bus.req_ready), 32'(1 << (i % 4)));
      tick();
      check("rr_pulse", 32'(bus.req_ready), 32'd0);
      tick();
      check("rr_id", 32'(bus.rsp_id), 32'(i % 4));
      check("rr_result", 32'(bus.rsp_result), 32'((i % 4) + 1));
      tick();
    end
    bus.req_valid = '0;
    tick();

    run_op("sub", 2, 4'h3, 4'h5, OP_SUB, 5'h1E);
    run_op("not", 2, 4'h3, 4'h5, OP_NOT, 5'h1C);
    run_op("mul", 2, 4'h3, 4'h5, OP_MUL, 5'h0F);
    run_op("xnor", 2, 4'h3, 4'h5, OP_XNOR, 5'h19);
    run_op("xor", 2, 4'h3, 4'h5, OP_XOR, 5'h06);
    run_op("and", 2, 4'h3, 4'h5, OP_AND, 5'h01);
    run_op("or", 2, 4'h3, 4'h5, OP_OR, 5'h07);

    // Backpressure for 5 cycles while every requester is asking.
    set_req(0, 4'hC, 4'hA, OP_AND);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0001;
    #1;
    check("bp_ready", 32'(bus.req_ready), 32'b0001);
    tick();
    bus.req_valid = '1;
    tick();
`ifdef ALU_ARB_PERF_EN
    p_stall0 = perf_stall;
    p_ops0   = perf_ops;
`endif
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_result", 32'(bus.rsp_result), 32'h08);
      check("bp_id", 32'(bus.rsp_id), 32'd0);
      check("bp_no_ready", 32'(bus.req_ready), 32'd0);
      tick();
    end
`ifdef ALU_ARB_PERF_EN
    check("perf_stall", 32'(perf_stall), 32'(p_stall0 + 16'd5));
`endif
    check("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
    bus.rsp_ready = 1'b1;
    tick();
    check("bp_release", 32'(bus.rsp_valid), 32'd0);
`ifdef ALU_ARB_PERF_EN
    check("perf_ops", 32'(perf_ops), 32'(p_ops0 + 16'd1));
`endif
    check("bp_next_grant", 32'(bus.req_ready), 32'b0010);
    bus.req_valid = '0;
    tick();

    // Requester 3 served, so pointer wraps to 0 and 0 beats 3.
    run_op("wrap_r3", 3, 4'h2, 4'h3, OP_MUL, 5'h06);
    bus.req_valid = 4'b1001;
    #1;
    check("wrap_grant", 32'(bus.req_ready), 32'b0001);
    bus.req_valid = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 4-bit, 8-opcode ALU datapath among NREQ requesters.
- Each requester issues ops over a valid/ready handshake.
- Grants are round-robin: one op is latched, executed, and the 5-bit result is returned on a single response channel tagged with the requester ID and subject to backpressure.
- Sits between multiple ALU clients and the team's shared combinational ALU.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width, equal to clog2(NREQ).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept strobe; at most one bit high, one cycle.
- req_a  in  4*NREQ  operand A, packed; slice i belongs to requester i.
- req_b  in  4*NREQ  operand B, packed.
- req_op  in  3*NREQ  opcode, packed.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_result  out  5  ALU result.
- rsp_id  out  IDW  index of the requester that issued this op.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0.
  - req_ready=0, rsp_valid=0, rsp_result=0, rsp_id=0, busy=0.
  - Takes effect mid-operation: any in-flight op is discarded and no response is issued.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid bit is set, pick the first set bit scanning from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ...).
  - Drive req_ready[g]=1 combinationally in that same cycle.
  - Latch a, b, op and g into holding registers; next state EXEC.
  - If no req_valid bit is set, stay in IDLE.
- EXEC: ALU evaluates the latched operands; register the result into rsp_result and g into rsp_id; next state RESP.
- RESP:
  - rsp_valid=1; rsp_result and rsp_id stay stable until rsp_ready=1.
  - On the rsp_ready=1 edge: rr_ptr = (g+1) mod NREQ, then go to IDLE.
  - rsp_ready in any other state is ignored.
- Latency: handshake at cycle T gives rsp_valid at T+2 (with rsp_ready tied high, rsp_valid is high at T+2 only). Peak throughput is 1 op per 3 cycles.
- Requester rules:
  - Operands must be held stable while req_valid=1 and req_ready=0.
  - Dropping req_valid before ready is legal; nothing is recorded.
  - req_ready is never asserted outside IDLE.
- Fairness: the requester just served has lowest priority next round. With all NREQ requesters continuously valid, each one is served within NREQ grants.
- ALU function (5-bit result; operands zero-extended to 5 bits before the operation):
  - 0 add: a+b.
  - 1 sub: a-b mod 32.
  - 2 and.
  - 3 or.
  - 4 not: ~a, so bit4=1.
  - 5 mul: a*b truncated to 5 bits.
  - 6 xor.
  - 7 xnor: bit4=1.
- Pointer wrap: when g=NREQ-1, rr_ptr becomes 0.

Optional Feature:
- Macro: ALU_ARB_PERF_EN.
- When defined, adds output perf_ops (16b) and output perf_stall (16b):
  - perf_ops counts completed responses (RESP exit).
  - perf_stall counts cycles with rsp_valid=1 and rsp_ready=0.
  - Both counters saturate at 16'hFFFF and reset to 0.
- When undefined, neither port nor counter exists and behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_ADD..OP_XNOR (values 0..7);
  - the FSM state enum (IDLE=0, EXEC=1, RESP=2);
  - the operand/result widths (4 and 5).
- One sub-module, rr_arbiter: inputs req vector and rr_ptr, outputs a one-hot grant and encoded index, purely combinational.
- The ALU is instantiated as an existing leaf and is not reimplemented.

Test Plan:
- Reset mid-RESP: assert rst_n=0 while rsp_valid=1 -> rsp_valid=0 immediately (async); after release, state=IDLE and rr_ptr=0.
- Single requester: req 1 with a=4'hF, b=4'h1, op=0 -> req_ready[1] at T; at T+2 rsp_valid=1, rsp_result=5'h10, rsp_id=1.
- Opcode sweep: a=4'h3, b=4'h5 ->
  - sub = 5'h1E;
  - not = 5'h1C;
  - mul = 5'h0F;
  - xnor = 5'h19;
  - xor = 5'h06.
- All 4 requesters continuously valid, rsp_ready=1 -> grant order 0,1,2,3,0,1; each req_ready pulse lasts exactly one cycle.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_result and rsp_id stable, no req_ready asserted; with PERF enabled, perf_stall increments by 5.
- Requester 3 granted, then requesters 0 and 3 valid -> next grant is 0 (wrap past NREQ-1).
